// File: rtl/prefetch_tb_pkg.sv
// Shared types for the strided AR request generator: FSM state encoding,
// sticky error bit positions and the outstanding-counter width.
package prefetch_tb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int ERR_LAST = 0;
    localparam int ERR_ID   = 1;

    // Wide enough for MAX_OUTSTANDING up to 15.
    localparam int OUT_W = 4;

    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/stride_req_gen_if.sv
// AXI-style read address (AR) and read data (R) channel bundle.
interface stride_req_gen_if #(
    parameter int ADDR_BITS       = 16,
    parameter int BURST_LEN_WIDTH = 8,
    parameter int TID_WIDTH       = 8,
    parameter int DATA_BITS       = 8
);
    logic                       m_ar_valid;
    logic                       m_ar_ready;
    logic [ADDR_BITS-1:0]       m_ar_addr;
    logic [BURST_LEN_WIDTH-1:0] m_ar_len;
    logic [TID_WIDTH-1:0]       m_ar_id;

    logic                       m_r_valid;
    logic                       m_r_ready;
    logic [DATA_BITS-1:0]       m_r_data;
    logic                       m_r_last;
    logic [TID_WIDTH-1:0]       m_r_id;

    modport master (
        output m_ar_valid, m_ar_addr, m_ar_len, m_ar_id, m_r_ready,
        input  m_ar_ready, m_r_valid, m_r_data, m_r_last, m_r_id
    );

    modport slave (
        input  m_ar_valid, m_ar_addr, m_ar_len, m_ar_id, m_r_ready,
        output m_ar_ready, m_r_valid, m_r_data, m_r_last, m_r_id
    );
endinterface

// File: rtl/outstanding_cnt.sv
// In-flight burst counter: +1 per AR accept, -1 per R-last, never
// underflows, flags full at MAX_OUTSTANDING.
module outstanding_cnt
    import prefetch_tb_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    input  logic             dec,
    output logic [OUT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic dec_ok;

    // A stray R-last with nothing in flight is an error, not a decrement.
    assign dec_ok = dec && !empty;
    assign empty  = (count == '0);
    assign full   = (count >= OUT_W'(MAX_OUTSTANDING));

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else begin
            case ({inc, dec_ok})
                2'b10:   if (!full) count <= count + OUT_W'(1);
                2'b01:   count <= count - OUT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/stride_req_gen.sv
// Issues cfg_req_num AR bursts at base, base+stride, ... with a cap on
// in-flight bursts, accepts and checks the R beats, and pulses done.
module stride_req_gen
    import prefetch_tb_pkg::*;
#(
    parameter int ADDR_BITS       = 16,
    parameter int BURST_LEN_WIDTH = 8,
    parameter int TID_WIDTH       = 8,
    parameter int DATA_BITS       = 8,
    parameter int REQ_CNT_WIDTH   = 8,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [ADDR_BITS-1:0]       cfg_base,
    input  logic [ADDR_BITS-1:0]       cfg_stride,
    input  logic [BURST_LEN_WIDTH-1:0] cfg_len,
    input  logic [TID_WIDTH-1:0]       cfg_id,
    input  logic [REQ_CNT_WIDTH-1:0]   cfg_req_num,
    stride_req_gen_if.master           bus,
    output logic                       busy,
    output logic                       done,
    output logic [15:0]                beat_cnt,
    output logic [1:0]                 err
);

    state_t                     state;
    state_t                     state_next;

    logic [ADDR_BITS-1:0]       addr_q;
    logic [ADDR_BITS-1:0]       stride_q;
    logic [BURST_LEN_WIDTH-1:0] len_q;
    logic [TID_WIDTH-1:0]       id_q;
    logic [REQ_CNT_WIDTH-1:0]   req_num_q;
    logic [REQ_CNT_WIDTH-1:0]   issued;
    logic [BURST_LEN_WIDTH-1:0] beat_idx;
    logic [15:0]                beat_cnt_q;
    logic [1:0]                 err_q;

    logic [OUT_W-1:0]           out_cnt;
    logic                       out_full;
    logic                       out_empty;

    logic start_ok;
    logic ar_hs;
    logic r_hs;
    logic r_last_hs;
    logic last_issue;
    logic drain_done;
    logic last_err;
    logic id_err;

    assign start_ok   = start && (state == ST_IDLE);
    assign ar_hs      = bus.m_ar_valid && bus.m_ar_ready;
    assign r_hs       = bus.m_r_valid && bus.m_r_ready;
    assign r_last_hs  = r_hs && bus.m_r_last;
    assign last_issue = ar_hs && (issued == req_num_q - REQ_CNT_WIDTH'(1));

    // Look ahead one beat so done follows the final R-last by one cycle.
    assign drain_done = out_empty ||
                        ((out_cnt == OUT_W'(1)) && r_last_hs && !ar_hs);

    assign last_err = out_empty || (bus.m_r_last != (beat_idx == len_q));
    assign id_err   = (bus.m_r_id != id_q);

    assign busy           = (state == ST_ISSUE) || (state == ST_DRAIN);
    assign done           = (state == ST_DONE);
    assign beat_cnt       = beat_cnt_q;
    assign err            = err_q;

    assign bus.m_ar_valid = (state == ST_ISSUE) && !out_full;
    assign bus.m_ar_addr  = addr_q;
    assign bus.m_ar_len   = len_q;
    assign bus.m_ar_id    = id_q;
    assign bus.m_r_ready  = busy;

    outstanding_cnt #(
        .MAX_OUTSTANDING (MAX_OUTSTANDING)
    ) u_outstanding_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (start_ok),
        .inc   (ar_hs),
        .dec   (r_last_hs),
        .count (out_cnt),
        .full  (out_full),
        .empty (out_empty)
    );

    // NOTE: state_next is defaulted before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (start) state_next = (cfg_req_num == '0) ? ST_DONE : ST_ISSUE;
            ST_ISSUE: if (last_issue) state_next = ST_DRAIN;
            ST_DRAIN: if (drain_done) state_next = ST_DONE;
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            stride_q  <= '0;
            len_q     <= '0;
            id_q      <= '0;
            req_num_q <= '0;
        end else begin
            state <= state_next;
            if (start_ok) begin
                stride_q  <= cfg_stride;
                len_q     <= cfg_len;
                id_q      <= cfg_id;
                req_num_q <= cfg_req_num;
            end
        end
    end

    // Address advances modulo 2^ADDR_BITS; a negative stride is just a wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q <= '0;
            issued <= '0;
        end else if (start_ok) begin
            addr_q <= cfg_base;
            issued <= '0;
        end else if (ar_hs) begin
            addr_q <= addr_q + stride_q;
            issued <= issued + REQ_CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_idx   <= '0;
            beat_cnt_q <= '0;
            err_q      <= '0;
        end else if (start_ok) begin
            beat_idx   <= '0;
            beat_cnt_q <= '0;
            err_q      <= '0;
        end else if (r_hs) begin
            beat_cnt_q <= sat_inc16(beat_cnt_q);
            beat_idx   <= bus.m_r_last ? '0 : beat_idx + BURST_LEN_WIDTH'(1);
            if (last_err) err_q[ERR_LAST] <= 1'b1;
            if (id_err)   err_q[ERR_ID]   <= 1'b1;
        end
    end

endmodule

// File: doc/stride_req_gen.md
STRIDE_REQ_GEN -- requirements
Module: stride_req_gen

Interface
REQ-001 SHALL have parameters (name, default, meaning), one per line:
  ADDR_BITS 16 address width
  BURST_LEN_WIDTH 8 AR len width
  TID_WIDTH 8 transaction ID width
  DATA_BITS 8 R data width
  REQ_CNT_WIDTH 8 request-count width
  MAX_OUTSTANDING 4 max in-flight bursts (1..15)
REQ-002 SHALL have ports (name direction width meaning), one per line, clock and reset first:
  clk in 1 single clock, rising edge
  rst in 1 asynchronous, active-high reset
  start in 1 one-cycle pulse; latches cfg_* and begins a run
  cfg_base in ADDR_BITS first burst address
  cfg_stride in ADDR_BITS two's-complement address step between bursts
  cfg_len in BURST_LEN_WIDTH AXI len (beats-1)
  cfg_id in TID_WIDTH ID driven on every AR
  cfg_req_num in REQ_CNT_WIDTH bursts per run (0 = empty run)
  m_ar_valid/m_ar_ready out/in 1 AR handshake
  m_ar_addr/m_ar_len/m_ar_id out ADDR_BITS/BURST_LEN_WIDTH/TID_WIDTH AR payload
  m_r_valid/m_r_ready in/out 1 R handshake
  m_r_data/m_r_last/m_r_id in DATA_BITS/1/TID_WIDTH R payload
  busy out 1 run in progress
  done out 1 one-cycle pulse at end of run
  beat_cnt out 16 total R beats accepted this run
  err out 2 sticky: bit0 last-position error, bit1 ID mismatch

Function
REQ-003 SHALL implement FSM IDLE -> ISSUE -> DRAIN -> DONE -> IDLE.
REQ-004 IDLE: start latches cfg_* and clears beat_cnt, err, counters; next state ISSUE, or DONE if cfg_req_num==0; start ignored outside IDLE.
REQ-005 ISSUE: m_ar_valid=1 iff outstanding<MAX_OUTSTANDING; payload held stable while valid && !ready.
REQ-006 AR handshake: addr <= addr+stride modulo 2^ADDR_BITS (wrap, no error); issued count +1; outstanding +1.
REQ-007 ISSUE -> DRAIN in the cycle after the cfg_req_num-th AR handshake.
REQ-008 m_r_ready SHALL be 1 whenever busy; each R handshake increments beat_cnt (saturates at 0xFFFF) and per-burst beat index.
REQ-009 Beat with m_r_last=1 SHALL decrement outstanding and reset beat index to 0.
REQ-010 Same-cycle AR handshake and R-last handshake: outstanding unchanged.
REQ-011 err[0] sets if last=1 at beat index != cfg_len, or last=0 at beat index == cfg_len; err[1] sets if m_r_id != cfg_id.
REQ-012 R handshake with outstanding==0 SHALL set err[0] and leave outstanding at 0 (no underflow).
REQ-013 DRAIN -> DONE when outstanding==0; DONE asserts done for exactly one cycle, then IDLE.
REQ-014 busy=1 in ISSUE and DRAIN only.
REQ-015 Latency: first m_ar_valid in the cycle after start; done one cycle after the final R-last handshake.

Reset
REQ-016 rst asynchronously forces IDLE; m_ar_valid=0, m_r_ready=0, busy=0, done=0, beat_cnt=0, err=0, m_ar_addr/len/id=0, counters=0.
REQ-017 rst mid-run SHALL abandon in-flight bursts; beats arriving after rst deassertion are not accepted (m_r_ready=0 in IDLE).

Structure
REQ-018 FSM state enum and err bit indices SHALL live in a shared package, prefetch_tb_pkg.
REQ-019 The outstanding counter (inc/dec/saturate, full flag) SHALL be sub-module outstanding_cnt; the rest is flat.

Verification
REQ-020 base=0x0EEF, stride=1, len=2, req_num=3, id=5, ready tied 1 -> ARs at 0x0EEF/0x0EF0/0x0EF1, beat_cnt=9, err=0, one done pulse.
REQ-021 MAX_OUTSTANDING=2, R responses withheld -> exactly 2 ARs issued, m_ar_valid low until the first R-last.
REQ-022 base=0xFFFE, stride=0xFFFF(-1)... then base=0xFFFF, stride=2, req_num=2 -> second AR addr 0x0001 (wrap), err=0.
REQ-023 len=2, memory asserts last on beat 1 -> err=2'b01, run still completes with done.
REQ-024 R beat with id=6 against cfg_id=5 -> err[1]=1; AR accept and R-last in the same cycle -> outstanding unchanged.
REQ-025 rst asserted mid-DRAIN -> all outputs at reset values immediately (asynchronously); new start after release runs cleanly.
